// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: fetch, decode, execute, memory and write-back sequencing.
// Outputs decode combinationally from the state and the latched opcode.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       br_cond,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic [2:0] imm_sel,
  output logic [1:0] alu_src_a,
  output logic       alu_src_b,
  output logic       reg_we,
  output logic [1:0] wb_sel,
  output logic       retire,
  output logic       illegal,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StTrap   = 3'd5
  } state_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;

  localparam logic [2:0] ImmI    = 3'd0;
  localparam logic [2:0] ImmS    = 3'd1;
  localparam logic [2:0] ImmB    = 3'd2;
  localparam logic [2:0] ImmU    = 3'd3;
  localparam logic [2:0] ImmJ    = 3'd4;
  localparam logic [2:0] ImmNone = 3'd7;

  state_e     state_q, state_d;
  logic [6:0] op_q, op_d;

  function automatic logic [2:0] imm_of(input logic [6:0] op);
    case (op)
      OpLoad, OpImm, OpJalr: imm_of = ImmI;
      OpStore:               imm_of = ImmS;
      OpBranch:              imm_of = ImmB;
      OpLui, OpAuipc:        imm_of = ImmU;
      OpJal:                 imm_of = ImmJ;
      default:               imm_of = ImmNone;
    endcase
  endfunction

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OpLoad, OpStore, OpImm, OpReg, OpLui, OpAuipc, OpJal, OpJalr, OpBranch: is_legal = 1'b1;
      default: is_legal = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StFetch;
      op_q    <= 7'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 2'd0;
    imm_sel   = ImmNone;
    alu_src_a = 2'd0;
    alu_src_b = 1'b0;
    reg_we    = 1'b0;
    wb_sel    = 2'd0;
    retire    = 1'b0;
    illegal   = 1'b0;

    case (state_q)
      StFetch: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = StDecode;
        end
      end
      StDecode: begin
        op_d    = opcode;
        imm_sel = imm_of(opcode);
        state_d = is_legal(opcode) ? StExec : StTrap;
      end
      StExec: begin
        imm_sel = imm_of(op_q);
        state_d = StWb;
        case (op_q)
          OpReg: ;
          OpImm: alu_src_b = 1'b1;
          OpLoad, OpStore: begin
            alu_src_b = 1'b1;
            state_d   = StMem;
          end
          OpJalr: begin
            alu_src_b = 1'b1;
            pc_we     = 1'b1;
            pc_sel    = 2'd2;
          end
          OpAuipc: begin
            alu_src_a = 2'd1;
            alu_src_b = 1'b1;
          end
          OpLui: begin
            alu_src_a = 2'd2;
            alu_src_b = 1'b1;
          end
          OpJal: begin
            pc_we  = 1'b1;
            pc_sel = 2'd1;
          end
          OpBranch: begin
            // Branches resolve and retire here; no write-back.
            pc_we   = br_cond;
            pc_sel  = 2'd1;
            retire  = 1'b1;
            state_d = StFetch;
          end
          default: state_d = StFetch;
        endcase
      end
      StMem: begin
        dmem_req = 1'b1;
        dmem_we  = (op_q == OpStore);
        if (dmem_ready) begin
          if (op_q == OpStore) begin
            retire  = 1'b1;
            state_d = StFetch;
          end else begin
            state_d = StWb;
          end
        end
      end
      StWb: begin
        reg_we  = 1'b1;
        retire  = 1'b1;
        state_d = StFetch;
        if (op_q == OpLoad) begin
          wb_sel = 2'd1;
        end else if (op_q == OpJal || op_q == OpJalr) begin
          wb_sel = 2'd2;
        end
      end
      StTrap: illegal = 1'b1;
      default: state_d = StFetch;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl with hand-computed expectations.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic       br_cond;
  logic       imem_ready;
  logic       dmem_ready;
  logic       imem_req;
  logic       dmem_req;
  logic       dmem_we;
  logic       ir_we;
  logic       pc_we;
  logic [1:0] pc_sel;
  logic [2:0] imm_sel;
  logic [1:0] alu_src_a;
  logic       alu_src_b;
  logic       reg_we;
  logic [1:0] wb_sel;
  logic       retire;
  logic       illegal;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;
  int retire_cnt = 0;
  int reg_we_cnt = 0;

  multicycle_ctrl u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .opcode    (opcode),
    .br_cond   (br_cond),
    .imem_ready(imem_ready),
    .dmem_ready(dmem_ready),
    .imem_req  (imem_req),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .pc_sel    (pc_sel),
    .imm_sel   (imm_sel),
    .alu_src_a (alu_src_a),
    .alu_src_b (alu_src_b),
    .reg_we    (reg_we),
    .wb_sel    (wb_sel),
    .retire    (retire),
    .illegal   (illegal),
    .state     (state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (retire) retire_cnt++;
    if (reg_we) reg_we_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from FETCH with zero memory wait; checks EXEC selects, latency, WB.
  task automatic run_instr(input string name, input logic [6:0] op, input logic [1:0] exp_a,
                           input logic exp_b, input logic [2:0] exp_imm, input int exp_lat,
                           input logic exp_we, input logic [1:0] exp_wb);
    int lat;
    opcode     = op;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    #1;
    check({name, " fetch state"}, state, 0);
    check({name, " fetch ir_we"}, ir_we, 1);
    step();
    imem_ready = 1'b0;
    step();
    check({name, " exec state"}, state, 2);
    check({name, " alu_src_a"}, alu_src_a, exp_a);
    check({name, " alu_src_b"}, alu_src_b, exp_b);
    check({name, " imm_sel"}, imm_sel, exp_imm);
    lat = 2;
    while (!retire && lat < 20) begin
      step();
      lat++;
    end
    check({name, " latency"}, lat, exp_lat);
    check({name, " reg_we"}, reg_we, exp_we);
    check({name, " wb_sel"}, wb_sel, exp_wb);
    step();
    check({name, " back to fetch"}, state, 0);
  endtask

  initial begin
    int rc;
    int wc;
    rst_n      = 1'b0;
    opcode     = 7'd0;
    br_cond    = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    step();
    step();
    check("reset state", state, 0);
    check("reset imem_req", imem_req, 1);
    check("reset imm_sel", imm_sel, 7);
    check("reset pc_we", pc_we, 0);
    check("reset illegal", illegal, 0);
    rst_n = 1'b1;

    // FETCH holds without imem_ready
    step();
    check("fetch wait state", state, 0);
    check("fetch wait ir_we", ir_we, 0);

    // ADDI
    rc = retire_cnt;
    opcode     = 7'b0010011;
    imem_ready = 1'b1;
    #1;
    check("addi ir_we", ir_we, 1);
    check("addi pc_we", pc_we, 1);
    check("addi pc_sel", pc_sel, 0);
    step();
    check("addi decode state", state, 1);
    check("addi decode imm_sel", imm_sel, 0);
    check("addi decode imem_req", imem_req, 0);
    step();
    imem_ready = 1'b0;
    #1;
    check("addi exec state", state, 2);
    check("addi exec imm_sel", imm_sel, 0);
    check("addi exec alu_src_b", alu_src_b, 1);
    step();
    check("addi wb state", state, 4);
    check("addi wb reg_we", reg_we, 1);
    check("addi wb wb_sel", wb_sel, 0);
    step();
    check("addi end state", state, 0);
    check("addi retire count", retire_cnt - rc, 1);

    // SW with 3 wait cycles; opcode changes after decode to exercise op_q
    rc = retire_cnt;
    wc = reg_we_cnt;
    opcode     = 7'b0100011;
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    #1;
    check("sw decode imm_sel", imm_sel, 1);
    step();
    opcode     = 7'b0110011;
    dmem_ready = 1'b0;
    #1;
    check("sw exec imm_sel", imm_sel, 1);
    check("sw exec alu_src_b", alu_src_b, 1);
    step();
    for (int i = 0; i < 3; i++) begin
      check("sw mem state", state, 3);
      check("sw mem dmem_req", dmem_req, 1);
      check("sw mem dmem_we", dmem_we, 1);
      check("sw mem retire", retire, 0);
      step();
    end
    dmem_ready = 1'b1;
    #1;
    check("sw mem4 dmem_req", dmem_req, 1);
    check("sw mem4 dmem_we", dmem_we, 1);
    check("sw mem4 retire", retire, 1);
    step();
    dmem_ready = 1'b0;
    check("sw end state", state, 0);
    check("sw retire count", retire_cnt - rc, 1);
    check("sw reg_we count", reg_we_cnt - wc, 0);

    // BEQ not taken, then taken
    for (int t = 0; t < 2; t++) begin
      opcode     = 7'b1100011;
      br_cond    = t[0];
      imem_ready = 1'b1;
      step();
      imem_ready = 1'b0;
      #1;
      check("beq decode imm_sel", imm_sel, 2);
      step();
      check("beq exec imm_sel", imm_sel, 2);
      check("beq exec pc_we", pc_we, t[0]);
      check("beq exec pc_sel", pc_sel, 1);
      check("beq exec retire", retire, 1);
      step();
      check("beq end state", state, 0);
    end
    br_cond = 1'b0;

    // JALR
    opcode     = 7'b1100111;
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    step();
    check("jalr exec pc_we", pc_we, 1);
    check("jalr exec pc_sel", pc_sel, 2);
    check("jalr exec imm_sel", imm_sel, 0);
    step();
    check("jalr wb state", state, 4);
    check("jalr wb wb_sel", wb_sel, 2);
    check("jalr wb reg_we", reg_we, 1);
    check("jalr wb retire", retire, 1);
    step();

    run_instr("load", 7'b0000011, 2'd0, 1'b1, 3'd0, 4, 1'b1, 2'd1);
    run_instr("lui", 7'b0110111, 2'd2, 1'b1, 3'd3, 3, 1'b1, 2'd0);
    run_instr("auipc", 7'b0010111, 2'd1, 1'b1, 3'd3, 3, 1'b1, 2'd0);
    run_instr("op", 7'b0110011, 2'd0, 1'b0, 3'd7, 3, 1'b1, 2'd0);
    run_instr("jal", 7'b1101111, 2'd0, 1'b0, 3'd4, 3, 1'b1, 2'd2);

    // Illegal opcode traps until reset
    opcode     = 7'b0000000;
    imem_ready = 1'b1;
    step();
    step();
    dmem_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      check("trap state", state, 5);
      check("trap illegal", illegal, 1);
      check("trap imem_req", imem_req, 0);
      check("trap ir_we", ir_we, 0);
      step();
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    check("trap reset state", state, 0);
    check("trap reset illegal", illegal, 0);
    dmem_ready = 1'b0;

    // Reset during LOAD MEM
    opcode     = 7'b0000011;
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    step();
    step();
    check("ld mem state", state, 3);
    check("ld mem dmem_req", dmem_req, 1);
    check("ld mem dmem_we", dmem_we, 0);
    rc = retire_cnt;
    wc = reg_we_cnt;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    check("ld reset state", state, 0);
    check("ld reset dmem_req", dmem_req, 0);
    check("ld reset imem_req", imem_req, 1);
    check("ld reset retire", retire, 0);
    check("ld reset reg_we", reg_we, 0);
    step();
    check("ld reset retire count", retire_cnt - rc, 0);
    check("ld reset reg_we count", reg_we_cnt - wc, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
